// File: rtl/twiddle_seq_ctrl_if.sv
// Handshake/bus bundle for twiddle_seq_ctrl: control, loader, twiddle RAM port and twiddle stream.
// master = the controller, slave = its surroundings (loader, FFT control, RAM, butterfly unit).
interface twiddle_seq_ctrl_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_FFT = 8
);
   localparam int unsigned DEPTH = N_FFT / 2;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned SW    = $clog2(N_FFT);

   logic             start;
   logic             ld_start;
   logic             ld_valid;
   logic [WIDTH-1:0] ld_data;
   logic             ld_ready;
   logic             ld_done;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] ram_wdata;
   logic [WIDTH-1:0] ram_rdata;
   logic             tw_valid;
   logic             tw_ready;
   logic [WIDTH-1:0] tw_data;
   logic [SW-1:0]    tw_stage;
   logic             tw_last;
   logic             busy;
   logic             done;

   modport master (
      input  start, ld_start, ld_valid, ld_data, ram_rdata, tw_ready,
      output ld_ready, ld_done, ram_we, ram_addr, ram_wdata,
             tw_valid, tw_data, tw_stage, tw_last, busy, done
   );

   modport slave (
      output start, ld_start, ld_valid, ld_data, ram_rdata, tw_ready,
      input  ld_ready, ld_done, ram_we, ram_addr, ram_wdata,
             tw_valid, tw_data, tw_stage, tw_last, busy, done
   );
endinterface

// File: rtl/twiddle_seq_ctrl.sv
// Twiddle RAM owner: arbitrates the single RAM address between table reload and FFT run,
// and streams one twiddle per butterfly, stage by stage, over a valid/ready handshake.
module twiddle_seq_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_FFT = 8,
   parameter int unsigned DEPTH = N_FFT / 2
) (
   input logic                clk,
   input logic                rst_n,
   twiddle_seq_ctrl_if.master bus
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned SW   = $clog2(N_FFT);
   localparam int unsigned HALF = N_FFT / 2;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

   state_t           state, state_d;
   logic [AW-1:0]    ld_cnt, ld_cnt_d;
   logic [AW-1:0]    bfly, bfly_d;
   logic [SW-1:0]    stage, stage_d;
   logic [WIDTH-1:0] tw_data_q, tw_data_d;
   logic [SW-1:0]    tw_stage_q, tw_stage_d;
   logic             tw_valid_q, tw_valid_d;
   logic             tw_last_q, tw_last_d;
   logic             ld_done_q, ld_done_d;
   logic             done_q, done_d;

   logic [AW:0]      one_sh;
   logic [AW-1:0]    mask;
   logic [SW-1:0]    shamt;
   logic [AW-1:0]    run_addr;
   logic             last_pos;
   logic             fetch;

   // Stage s uses bfly mod 2^s, spread across the table by N/2^(s+1).
   always_comb begin
      one_sh   = (AW+1)'(1) << stage;
      mask     = AW'(one_sh - (AW+1)'(1));
      shamt    = SW'(SW - 1) - stage;
      run_addr = (bfly & mask) << shamt;
      last_pos = (stage == SW'(SW - 1)) && (bfly == AW'(HALF - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ld_cnt     <= '0;
         bfly       <= '0;
         stage      <= '0;
         tw_data_q  <= '0;
         tw_stage_q <= '0;
         tw_valid_q <= 1'b0;
         tw_last_q  <= 1'b0;
         ld_done_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_d;
         ld_cnt     <= ld_cnt_d;
         bfly       <= bfly_d;
         stage      <= stage_d;
         tw_data_q  <= tw_data_d;
         tw_stage_q <= tw_stage_d;
         tw_valid_q <= tw_valid_d;
         tw_last_q  <= tw_last_d;
         ld_done_q  <= ld_done_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d       = state;
      ld_cnt_d      = ld_cnt;
      bfly_d        = bfly;
      stage_d       = stage;
      tw_data_d     = tw_data_q;
      tw_stage_d    = tw_stage_q;
      tw_valid_d    = tw_valid_q;
      tw_last_d     = tw_last_q;
      ld_done_d     = 1'b0;
      done_d        = 1'b0;
      fetch         = 1'b0;
      bus.ld_ready  = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;

      case (state)
         IDLE: begin
            // A simultaneous run request is dropped in favour of the reload.
            if (bus.ld_start) begin
               state_d  = LOAD;
               ld_cnt_d = '0;
            end else if (bus.start) begin
               state_d = RUN;
               stage_d = '0;
               bfly_d  = '0;
            end
         end
         LOAD: begin
            bus.ld_ready  = 1'b1;
            bus.ram_we    = bus.ld_valid;
            bus.ram_addr  = ld_cnt;
            bus.ram_wdata = bus.ld_data;
            if (bus.ld_valid) begin
               if (ld_cnt == AW'(DEPTH - 1)) begin
                  ld_cnt_d  = '0;
                  ld_done_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  ld_cnt_d = ld_cnt + AW'(1);
               end
            end
         end
         RUN: begin
            bus.ram_addr = run_addr;
            fetch        = !tw_valid_q || bus.tw_ready;
            if (fetch) begin
               tw_data_d  = bus.ram_rdata;
               tw_stage_d = stage;
               tw_valid_d = 1'b1;
               tw_last_d  = last_pos;
               if (last_pos) begin
                  bfly_d  = '0;
                  stage_d = '0;
                  state_d = FLUSH;
               end else if (bfly == AW'(HALF - 1)) begin
                  bfly_d  = '0;
                  stage_d = stage + SW'(1);
               end else begin
                  bfly_d = bfly + AW'(1);
               end
            end
         end
         FLUSH: begin
            if (bus.tw_ready) begin
               tw_valid_d = 1'b0;
               tw_last_d  = 1'b0;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.tw_valid = tw_valid_q;
   assign bus.tw_data  = tw_data_q;
   assign bus.tw_stage = tw_stage_q;
   assign bus.tw_last  = tw_last_q;
   assign bus.ld_done  = ld_done_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_twiddle_seq_ctrl.sv
// Scoreboard bench for twiddle_seq_ctrl (N_FFT=8): expected RAM writes and twiddles are
// queued by the stimulus and popped by a negedge monitor when the DUT presents them.
module tb_twiddle_seq_ctrl;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned N_FFT = 8;

   typedef struct packed {
      logic [1:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  stage;
      logic        last;
   } tw_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   twiddle_seq_ctrl_if #(.WIDTH(WIDTH), .N_FFT(N_FFT)) bus ();

   twiddle_seq_ctrl #(.WIDTH(WIDTH), .N_FFT(N_FFT), .DEPTH(N_FFT/2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [31:0] mem [4];
   logic [31:0] tbl [4];
   wr_t         exp_wr [$];
   tw_t         exp_tw [$];

   // Hand-derived twiddle addresses for N=8: stage0 all 0, stage1 0,2,0,2, stage2 0..3.
   int unsigned addr_seq [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   logic [31:0] data_a [4]    = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
   logic [31:0] data_c [4]    = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
   assign bus.ram_rdata = mem[bus.ram_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: RAM writes, twiddle handshakes, stall stability, done ordering.
   logic        stall;
   logic [31:0] h_data;
   logic [2:0]  h_stage;
   logic        h_last;
   always @(negedge clk) begin
      wr_t ew;
      tw_t et;
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         if (bus.ram_we) begin
            if (exp_wr.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.ram_addr, bus.ram_wdata);
            end else begin
               ew = exp_wr.pop_front();
               check("wr_addr", 64'(bus.ram_addr), 64'(ew.addr));
               check("wr_data", 64'(bus.ram_wdata), 64'(ew.data));
            end
         end
         if (stall) begin
            check("stall_valid", 64'(bus.tw_valid), 64'(1));
            check("stall_data", 64'(bus.tw_data), 64'(h_data));
            check("stall_stage", 64'(bus.tw_stage), 64'(h_stage));
            check("stall_last", 64'(bus.tw_last), 64'(h_last));
         end
         if (bus.tw_valid && bus.tw_ready) begin
            if (exp_tw.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_twiddle: got data %0h stage %0d expected none", bus.tw_data, bus.tw_stage);
            end else begin
               et = exp_tw.pop_front();
               check("tw_data", 64'(bus.tw_data), 64'(et.data));
               check("tw_stage", 64'(bus.tw_stage), 64'(et.stage));
               check("tw_last", 64'(bus.tw_last), 64'(et.last));
            end
         end
         if (bus.done) check("done_after_all_twiddles", 64'(exp_tw.size()), 64'(0));
         stall   = bus.tw_valid && !bus.tw_ready;
         h_data  = bus.tw_data;
         h_stage = bus.tw_stage;
         h_last  = bus.tw_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tw_valid"}, 64'(bus.tw_valid), 64'(0));
      check({tag, "_tw_data"},  64'(bus.tw_data),  64'(0));
      check({tag, "_tw_stage"}, 64'(bus.tw_stage), 64'(0));
      check({tag, "_tw_last"},  64'(bus.tw_last),  64'(0));
      check({tag, "_busy"},     64'(bus.busy),     64'(0));
      check({tag, "_done"},     64'(bus.done),     64'(0));
      check({tag, "_ld_done"},  64'(bus.ld_done),  64'(0));
      check({tag, "_ld_ready"}, 64'(bus.ld_ready), 64'(0));
      check({tag, "_ram_we"},   64'(bus.ram_we),   64'(0));
      check({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'(0));
   endtask

   task automatic load_table(input logic [31:0] d [4], input bit gapped,
                             input bit with_start, input bit poke_start);
      for (int i = 0; i < 4; i++) begin
         exp_wr.push_back('{addr: 2'(i), data: d[i]});
         tbl[i] = d[i];
      end
      bus.ld_start = 1'b1;
      bus.start    = with_start;
      tick();
      bus.ld_start = 1'b0;
      bus.start    = 1'b0;
      check("load_ld_ready", 64'(bus.ld_ready), 64'(1));
      check("load_busy", 64'(bus.busy), 64'(1));
      for (int i = 0; i < 4; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = d[i];
         bus.start    = poke_start && (i == 1);
         tick();
         bus.start = 1'b0;
         if (gapped && i < 3) begin
            bus.ld_valid = 1'b0;
            bus.ld_data  = 32'hDEAD_BEEF;
            tick();
         end
      end
      bus.ld_valid = 1'b0;
      check("ld_done_pulse", 64'(bus.ld_done), 64'(1));
      check("load_exit_busy", 64'(bus.busy), 64'(0));
      tick();
      check("ld_done_single", 64'(bus.ld_done), 64'(0));
      check("idle_after_load", 64'(bus.busy), 64'(0));
      check("no_run_after_load", 64'(bus.tw_valid), 64'(0));
      check("writes_consumed", 64'(exp_wr.size()), 64'(0));
   endtask

   task automatic push_run();
      for (int i = 0; i < 12; i++)
         exp_tw.push_back('{data: tbl[addr_seq[i]], stage: 3'(i / 4), last: (i == 11)});
   endtask

   task automatic run_fft(input bit bp, input bit poke_ld);
      int cyc;
      bit seen;
      push_run();
      bus.tw_ready = 1'b1;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      check("valid_before_latency", 64'(bus.tw_valid), 64'(0));
      check("run_busy", 64'(bus.busy), 64'(1));
      bus.tw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      check("valid_latency", 64'(bus.tw_valid), 64'(1));
      check("first_stage", 64'(bus.tw_stage), 64'(0));
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         bus.tw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.ld_start = poke_ld && (cyc == 3);
         bus.ld_valid = poke_ld && (cyc == 3 || cyc == 4);
         bus.ld_data  = 32'hBAD0_0000;
         tick();
         cyc++;
         bus.ld_start = 1'b0;
         bus.ld_valid = 1'b0;
         if (bus.done) seen = 1;
      end
      check("done_seen", 64'(seen), 64'(1));
      if (!bp) check("done_cycle", 64'(cyc), 64'(12));
      check("run_end_busy", 64'(bus.busy), 64'(0));
      check("run_end_valid", 64'(bus.tw_valid), 64'(0));
      check("run_end_last", 64'(bus.tw_last), 64'(0));
      tick();
      check("done_single", 64'(bus.done), 64'(0));
      check("twiddles_consumed", 64'(exp_tw.size()), 64'(0));
      bus.tw_ready = 1'b1;
   endtask

   initial begin
      int guard;
      n_vec = 0;
      n_err = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      bus.tw_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;
      tick();
      check("idle_busy", 64'(bus.busy), 64'(0));

      load_table(data_c, 1'b1, 1'b0, 1'b0);
      load_table(data_a, 1'b0, 1'b0, 1'b0);
      run_fft(1'b0, 1'b0);
      run_fft(1'b1, 1'b0);
      load_table(data_a, 1'b0, 1'b1, 1'b1);
      run_fft(1'b0, 1'b1);

      // Abort a run while stage 1 is on the output, then restart from scratch.
      push_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      guard = 0;
      while (!(bus.tw_valid && bus.tw_stage == 3'd1) && guard < 50) begin
         tick();
         guard++;
      end
      check("reached_stage1", 64'(bus.tw_stage), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      exp_tw.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      run_fft(1'b0, 1'b0);

      check("final_wr_queue", 64'(exp_wr.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/twiddle_seq_ctrl.md
Name: twiddle_seq_ctrl

Overview:
Controller that owns the twiddle-coefficient RAM (one write port, combinational read, single shared address) for a radix-2 DIT FFT of N_FFT points.
It arbitrates between two requesters of that one address port: a coefficient loader that rewrites the table, and the FFT run sequencer.
During a run it streams one twiddle per butterfly, stage by stage, to the butterfly unit over a valid/ready handshake.
Sits between the coefficient loader / FFT top-level control and the w_re/w_im RAM pair; one instance per RAM.

Parameters:
WIDTH, 32, coefficient width in bits.
N_FFT, 8, FFT length; power of two, >= 4.
DEPTH, N_FFT/2, twiddle RAM depth; must equal N_FFT/2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  run request pulse; sampled in IDLE only.
ld_start  in  1  table reload request; sampled in IDLE only.
ld_valid  in  1  loader word valid.
ld_data  in  WIDTH  loader word.
ld_ready  out  1  loader word accepted this cycle when ld_valid & ld_ready.
ld_done  out  1  one-cycle pulse after the last table word is written.
ram_we  out  1  RAM write enable.
ram_addr  out  $clog2(DEPTH)  RAM address.
ram_wdata  out  WIDTH  RAM write data.
ram_rdata  in  WIDTH  RAM read data, combinational from ram_addr.
tw_valid  out  1  twiddle output valid.
tw_ready  in  1  butterfly unit accepts the twiddle.
tw_data  out  WIDTH  twiddle coefficient (registered).
tw_stage  out  $clog2(N_FFT)  stage index of tw_data.
tw_last  out  1  tw_data is the final twiddle of the run.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse after the final twiddle handshake.

Behaviour:
- S = log2(N_FFT). States: IDLE, LOAD, RUN, FLUSH.
- Reset (async, rst_n=0): state=IDLE; all counters 0; tw_valid=0, tw_data=0, tw_stage=0, tw_last=0; ld_ready=0, ld_done=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0.
- IDLE:
  - ld_start=1 -> LOAD, load counter=0.
  - else start=1 -> RUN, stage=0, bfly=0.
  - ld_start and start in the same cycle: LOAD wins; start is dropped, not queued.
  - start/ld_start outside IDLE are ignored.
- LOAD:
  - ld_ready=1.
  - ram_we = ld_valid; ram_addr = load counter; ram_wdata = ld_data (all combinational).
  - Each accepted word increments the load counter.
  - Word with counter = DEPTH-1 accepted -> IDLE next cycle, with ld_done=1 in that cycle.
  - ld_valid=0 stalls without writing.
- RUN:
  - ram_we=0.
  - ram_addr = (bfly & (2^stage - 1)) << (S-1-stage), computed combinationally from the counters.
  - Fetch occurs when tw_valid=0 or tw_ready=1. On fetch, the next edge does all of:
    - tw_data <= ram_rdata;
    - tw_stage <= stage;
    - tw_valid <= 1;
    - tw_last <= (stage=S-1 and bfly=N_FFT/2-1);
    - counters advance: bfly increments; at N_FFT/2-1 it wraps to 0 and stage increments.
  - Latency: first tw_valid is asserted 2 cycles after the start pulse (1 to enter RUN, 1 to register).
  - Back-to-back throughput is 1 twiddle/cycle while tw_ready=1.
  - tw_ready=0 with tw_valid=1: tw_* hold stable and the counters freeze.
  - After the last fetch -> FLUSH.
- FLUSH:
  - No further fetches.
  - On handshake of the tw_last word: tw_valid <= 0, tw_last <= 0, done=1 for one cycle, -> IDLE.
- Total twiddles per run: S*N_FFT/2. Stage s repeats its pattern with period 2^s.
- Reset mid-LOAD or mid-RUN aborts immediately to the reset values. RAM contents written so far are retained; no partial-state recovery.
- The RAM is never written while in RUN/FLUSH, and the run sequencer never drives the address in LOAD (the arbitration guarantee).

Test Plan:
- Reset mid-stream: assert rst_n=0 during RUN stage 1 -> all outputs 0 and IDLE asynchronously. Release, pulse start -> full sequence restarts from stage 0, bfly 0.
- Load: N_FFT=8, ld_start, then ld_data 0xA0..0xA3 with continuous ld_valid -> ram_we at addrs 0,1,2,3 with those data. ld_done 1 cycle after the 4th word. busy low afterward.
- Load with gaps: ld_valid toggled 1,0,1,0,... -> exactly 4 writes at addrs 0..3. No write on ld_valid=0 cycles. ld_done timing relative to the last word unchanged.
- Run, tw_ready=1: after the load above, start -> 12 twiddles.
  - stage0 addrs 0,0,0,0; stage1 0,2,0,2; stage2 0,1,2,3.
  - tw_data values map to 0xA0/0xA2 etc. accordingly.
  - First tw_valid 2 cycles after start; tw_last on the 12th; done the cycle after its handshake.
- Backpressure: tw_ready random 50% -> identical 12-word sequence, no loss or duplication, tw_* stable while stalled.
- Arbitration: start and ld_start in the same IDLE cycle -> LOAD entered, no RUN afterward. start pulsed during LOAD -> ignored. ld_start during RUN -> ignored, ram_we stays 0.
